// File: rtl/obi_mem_responder.sv
// In-order OBI-style memory responder: word-addressed backing array, stall-shaped grant/response timing.
// Define OBI_RESP_ERR_EN to add err_o and out-of-range address detection (default: addresses wrap).
module obi_mem_responder #(
    parameter int unsigned MEM_WORDS       = 256,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned LATENCY         = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    input  logic        gnt_stall_i,
    input  logic        rvalid_stall_i,
    output logic [2:0]  outstanding_o
`ifdef OBI_RESP_ERR_EN
    ,
    output logic        err_o
`endif
);

    localparam int unsigned IDX_W    = $clog2(MEM_WORDS);
    localparam int unsigned PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [2:0]  MAX_CNT  = 3'(MAX_OUTSTANDING);
    localparam logic [2:0]  LAT      = 3'(LATENCY);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

    logic [31:0]      mem_q [MEM_WORDS];
    logic [31:0]      slot_rdata_q [MAX_OUTSTANDING];
    logic [2:0]       slot_age_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0]       count_q, count_d;

    logic             push, pop, head_ready, wr_en;
    logic [IDX_W-1:0] word_idx;
    logic [31:0]      mem_rd_word, push_rdata;
    logic             unused_addr_bits;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign word_idx         = addr_i[2 +: IDX_W];
    assign unused_addr_bits = ^{addr_i[31:IDX_W+2], addr_i[1:0]};
    assign mem_rd_word      = mem_q[word_idx];

    // Full is judged on the pre-pop count; a same-cycle pop never opens a grant.
    assign gnt_o = rst_ni & req_i & ~gnt_stall_i & (count_q < MAX_CNT);
    assign push  = gnt_o;

`ifdef OBI_RESP_ERR_EN
    logic in_range;
    logic slot_err_q [MAX_OUTSTANDING];

    assign in_range   = (addr_i[31:IDX_W+2] == '0);
    assign wr_en      = push & we_i & in_range;
    assign push_rdata = (we_i || !in_range) ? 32'd0 : mem_rd_word;
`else
    assign wr_en      = push & we_i;
    assign push_rdata = we_i ? 32'd0 : mem_rd_word;
`endif

    assign head_ready    = (count_q != 3'd0) && (slot_age_q[rd_ptr_q] >= LAT);
    assign rvalid_o      = head_ready & ~rvalid_stall_i;
    assign pop           = rvalid_o;
    assign rdata_o       = rvalid_o ? slot_rdata_q[rd_ptr_q] : 32'd0;
    assign outstanding_o = count_q;

`ifdef OBI_RESP_ERR_EN
    assign err_o = rvalid_o & slot_err_q[rd_ptr_q];
`endif

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[word_idx][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Age counts cycles since grant; the grant cycle is age 0, so the first stored value is 1.
    for (genvar gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_slot
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                slot_rdata_q[gi] <= '0;
                slot_age_q[gi]   <= '0;
            end else if (push && (wr_ptr_q == PTR_W'(gi))) begin
                slot_rdata_q[gi] <= push_rdata;
                slot_age_q[gi]   <= 3'd1;
            end else if (slot_age_q[gi] < LAT) begin
                slot_age_q[gi]   <= slot_age_q[gi] + 3'd1;
            end
        end

`ifdef OBI_RESP_ERR_EN
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                slot_err_q[gi] <= 1'b0;
            end else if (push && (wr_ptr_q == PTR_W'(gi))) begin
                slot_err_q[gi] <= ~in_range;
            end
        end
`endif
    end

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert (count_q <= MAX_CNT);
            assert (!(pop && (count_q == 3'd0)));
        end
    end

endmodule

// File: tb/tb_obi_mem_responder.sv
// Directed bench for obi_mem_responder: default instance (LATENCY=1) plus a LATENCY=3 instance on shared inputs.
module tb_obi_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, req, we, gnt_stall, rvalid_stall;
    logic [31:0] addr, wdata;
    logic [3:0]  be;

    logic        gnt, rvalid, gnt3, rvalid3;
    logic [31:0] rdata, rdata3;
    logic [2:0]  outst, outst3;
`ifdef OBI_RESP_ERR_EN
    logic        err, err3;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int grants   = 0;

    obi_mem_responder #(.MEM_WORDS(256), .MAX_OUTSTANDING(2), .LATENCY(1)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we),
        .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata),
        .gnt_stall_i(gnt_stall), .rvalid_stall_i(rvalid_stall), .outstanding_o(outst)
`ifdef OBI_RESP_ERR_EN
        , .err_o(err)
`endif
    );

    obi_mem_responder #(.MEM_WORDS(256), .MAX_OUTSTANDING(2), .LATENCY(3)) u_dut_lat3 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt3), .addr_i(addr), .we_i(we),
        .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid3), .rdata_o(rdata3),
        .gnt_stall_i(gnt_stall), .rvalid_stall_i(rvalid_stall), .outstanding_o(outst3)
`ifdef OBI_RESP_ERR_EN
        , .err_o(err3)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] d);
        req = r; we = w; addr = a; be = b; wdata = d;
        #1;
        if (r) $display("t=%0t req %s addr=0x%08h be=%b wdata=0x%08h gnt=%0b rvalid=%0b rdata=0x%08h",
                        $time, w ? "WR" : "RD", a, b, d, gnt, rvalid, rdata);
    endtask

    initial begin
        // Reset state, with a request held to show grant is suppressed
        rst_n = 1'b0; req = 1'b1; we = 1'b0; addr = '0; be = '0; wdata = '0;
        gnt_stall = 1'b0; rvalid_stall = 1'b0;
        #2;
        check("rst_gnt",    32'(gnt), 32'd0);
        check("rst_gnt3",   32'(gnt3), 32'd0);
        check("rst_outst",  32'(outst), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rdata",  rdata, 32'd0);
        req = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;

        // Write then read back the same word
        next_cycle(); drive(1, 1, 32'h10, 4'hF, 32'hDEADBEEF);
        check("t1_wr_gnt",    32'(gnt), 32'd1);
        check("t1_wr_rvalid", 32'(rvalid), 32'd0);
        next_cycle(); drive(1, 0, 32'h10, 4'hF, 32'h0);
        check("t1_rd_gnt",    32'(gnt), 32'd1);
        check("t1_wr_resp",   32'(rvalid), 32'd1);
        check("t1_wr_rdata",  rdata, 32'd0);
        check("t1_outst1",    32'(outst), 32'd1);
        next_cycle(); drive(0, 0, 32'h0, 4'h0, 32'h0);
        check("t1_rd_resp",   32'(rvalid), 32'd1);
        check("t1_rd_rdata",  rdata, 32'hDEADBEEF);
        next_cycle();
        check("t1_idle_rvalid", 32'(rvalid), 32'd0);
        check("t1_idle_outst",  32'(outst), 32'd0);

        // Byte-enable merge
        next_cycle(); drive(1, 1, 32'h20, 4'hF, 32'h11223344);
        check("t2_gnt", 32'(gnt), 32'd1);
        next_cycle(); drive(1, 1, 32'h20, 4'b0101, 32'hAABBCCDD);
        check("t2_w1_resp", 32'(rvalid), 32'd1);
        next_cycle(); drive(1, 0, 32'h20, 4'hF, 32'h0);
        check("t2_w2_resp", 32'(rvalid), 32'd1);
        check("t2_w2_rdata", rdata, 32'd0);
        next_cycle(); drive(0, 0, 32'h0, 4'h0, 32'h0);
        check("t2_rd_resp", 32'(rvalid), 32'd1);
        check("t2_rd_rdata", rdata, 32'h11BB33DD);
        next_cycle();
        check("t2_idle", 32'(rvalid), 32'd0);

        // Response stall fills the FIFO; grants stop at MAX_OUTSTANDING
        grants = 0;
        next_cycle(); rvalid_stall = 1'b1; drive(1, 0, 32'h10, 4'hF, 32'h0);
        grants += int'(gnt);
        next_cycle(); drive(1, 0, 32'h20, 4'hF, 32'h0);
        grants += int'(gnt);
        for (int i = 0; i < 3; i++) begin
            next_cycle(); drive(1, 0, 32'h20, 4'hF, 32'h0);
            grants += int'(gnt);
            check("t3_stall_rvalid", 32'(rvalid), 32'd0);
        end
        check("t3_grants", 32'(grants), 32'd2);
        check("t3_full_gnt", 32'(gnt), 32'd0);
        check("t3_outst2", 32'(outst), 32'd2);
        next_cycle(); rvalid_stall = 1'b0; drive(1, 0, 32'h20, 4'hF, 32'h0);
        check("t3_r1_valid", 32'(rvalid), 32'd1);
        check("t3_r1_rdata", rdata, 32'hDEADBEEF);
        check("t3_pop_nogrant", 32'(gnt), 32'd0);
        next_cycle(); drive(1, 0, 32'h20, 4'hF, 32'h0);
        check("t3_r2_valid", 32'(rvalid), 32'd1);
        check("t3_r2_rdata", rdata, 32'h11BB33DD);
        check("t3_resume_gnt", 32'(gnt), 32'd1);
        check("t3_outst1", 32'(outst), 32'd1);
        next_cycle(); drive(0, 0, 32'h0, 4'h0, 32'h0);
        check("t3_r3_valid", 32'(rvalid), 32'd1);
        check("t3_r3_rdata", rdata, 32'h11BB33DD);
        check("t3_pushpop_outst", 32'(outst), 32'd1);
        next_cycle();
        check("t3_drain_rvalid", 32'(rvalid), 32'd0);
        check("t3_drain_outst", 32'(outst), 32'd0);

        // Reset with two pending entries
        next_cycle(); rvalid_stall = 1'b1; drive(1, 0, 32'h10, 4'hF, 32'h0);
        next_cycle(); drive(1, 0, 32'h20, 4'hF, 32'h0);
        next_cycle(); drive(0, 0, 32'h0, 4'h0, 32'h0);
        check("t5_pending", 32'(outst), 32'd2);
        rvalid_stall = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t5_rst_outst", 32'(outst), 32'd0);
        check("t5_rst_rvalid", 32'(rvalid), 32'd0);
        check("t5_rst_outst3", 32'(outst3), 32'd0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            check("t5_post_rvalid", 32'(rvalid), 32'd0);
            check("t5_post_rvalid3", 32'(rvalid3), 32'd0);
        end

        // LATENCY=3 instance: write then read, responses at grant+3 in order
        next_cycle(); drive(1, 1, 32'h40, 4'hF, 32'hCAFEF00D);
        check("t4_w_gnt3", 32'(gnt3), 32'd1);
        check("t4_w_gnt", 32'(gnt), 32'd1);
        next_cycle(); drive(1, 0, 32'h40, 4'hF, 32'h0);
        check("t4_r_gnt3", 32'(gnt3), 32'd1);
        check("t4_c1_rvalid3", 32'(rvalid3), 32'd0);
        check("t4_c1_rvalid_lat1", 32'(rvalid), 32'd1);
        next_cycle(); drive(0, 0, 32'h0, 4'h0, 32'h0);
        check("t4_c2_rvalid3", 32'(rvalid3), 32'd0);
        check("t4_c2_outst3", 32'(outst3), 32'd2);
        next_cycle();
        check("t4_c3_rvalid3", 32'(rvalid3), 32'd1);
        check("t4_c3_rdata3", rdata3, 32'd0);
        next_cycle();
        check("t4_c4_rvalid3", 32'(rvalid3), 32'd1);
        check("t4_c4_rdata3", rdata3, 32'hCAFEF00D);
        next_cycle();
        check("t4_c5_rvalid3", 32'(rvalid3), 32'd0);
        check("t4_c5_outst3", 32'(outst3), 32'd0);

        // Address 0x400: out of range with error support, otherwise wraps onto word 0
        next_cycle(); drive(1, 1, 32'h0, 4'hF, 32'h0BADF00D);
        next_cycle(); drive(1, 1, 32'h400, 4'hF, 32'h12345678);
        check("t6_w0_resp", 32'(rvalid), 32'd1);
`ifdef OBI_RESP_ERR_EN
        check("t6_w0_err", 32'(err), 32'd0);
`endif
        next_cycle(); drive(1, 0, 32'h400, 4'hF, 32'h0);
        check("t6_w400_resp", 32'(rvalid), 32'd1);
        check("t6_w400_rdata", rdata, 32'd0);
`ifdef OBI_RESP_ERR_EN
        check("t6_w400_err", 32'(err), 32'd1);
`endif
        next_cycle(); drive(1, 0, 32'h0, 4'hF, 32'h0);
        check("t6_r400_resp", 32'(rvalid), 32'd1);
`ifdef OBI_RESP_ERR_EN
        check("t6_r400_rdata", rdata, 32'd0);
        check("t6_r400_err", 32'(err), 32'd1);
`else
        check("t6_r400_rdata_wrap", rdata, 32'h12345678);
`endif
        next_cycle(); drive(0, 0, 32'h0, 4'h0, 32'h0);
        check("t6_r0_resp", 32'(rvalid), 32'd1);
`ifdef OBI_RESP_ERR_EN
        check("t6_r0_rdata", rdata, 32'h0BADF00D);
        check("t6_r0_err", 32'(err), 32'd0);
`else
        check("t6_r0_rdata_wrap", rdata, 32'h12345678);
`endif
        next_cycle();
        check("t6_idle", 32'(rvalid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
